// File: rtl/encode_6466b.sv
// ---------------------------------------------------------------------------
// encode_6466b
//
// 64b/66b block encoder (Clause 49 style) for the 10G TX path. Two 32-bit
// XGMII-like words (4 lanes + 4 control flags each) are paired into one
// 8-lane block and encoded into a 64-bit payload plus a 2-bit sync header.
// No scrambling is done here; the output feeds the scrambler/gearbox.
//
// Ports:
//   i_txc        TX clock (only clock)
//   i_reset      asynchronous reset, active low
//   i_init_done  PCS init complete; while low the encoder sits in reset state
//   i_txd        XGMII data, byte k = lane k
//   i_txctl      XGMII control flags, bit k = lane k is a control character
//   i_tx_pause   gearbox stall; the input word is not consumed this cycle
//   o_txd        encoded payload; [7:0] is the block type for control blocks
//   o_tx_header  sync header, bit 0 sent first (data 2'b10, control 2'b01)
//   o_phase      debug view of the pairing state (1 = lanes 0-3 held)
//
// Handshake: there is no valid/ready pair. A word is consumed on every
// rising edge where i_init_done = 1 and i_tx_pause = 0; the first consumed
// word of a pair is lanes 0-3, the second is lanes 4-7. The encoded block
// appears on the edge that consumes the second word and is held until the
// next block completes.
// ---------------------------------------------------------------------------
module encode_6466b (
    input  logic        i_txc,
    input  logic        i_reset,
    input  logic        i_init_done,
    input  logic [31:0] i_txd,
    input  logic [3:0]  i_txctl,
    input  logic        i_tx_pause,
    output logic [63:0] o_txd,
    output logic [1:0]  o_tx_header,
    output logic        o_phase
);

    // XGMII character codes
    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;

    // 7-bit control codes used inside control blocks
    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    // Block type fields
    localparam logic [7:0] TYPE_CTRL   = 8'h1E;
    localparam logic [7:0] TYPE_START0 = 8'h78;
    localparam logic [7:0] TYPE_START4 = 8'h33;

    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_CTRL = 2'b01;

    // All-idle control block (every code is 0x00) and the error block
    // (every code is the error code).
    localparam logic [63:0] IDLE_BLOCK = 64'h0000_0000_0000_001E;
    localparam logic [63:0] ERR_BLOCK  = {{8{CODE_ERROR}}, TYPE_CTRL};

    typedef enum logic {
        PH_LOW  = 1'b0,   // waiting for lanes 0-3
        PH_HIGH = 1'b1    // lanes 0-3 held, waiting for lanes 4-7
    } phase_t;

    phase_t      phase;
    logic [31:0] lo_txd;
    logic [3:0]  lo_ctl;

    // Full 8-lane view: the held half plus the word currently presented.
    // Only meaningful while phase = PH_HIGH.
    logic [63:0] blk_d;
    logic [7:0]  blk_c;

    assign blk_d = {i_txd, lo_txd};
    assign blk_c = {i_txctl, lo_ctl};

    // ------------------------------------------------------------------
    // Per-lane decode
    // ------------------------------------------------------------------
    logic [7:0] lane [8];
    logic [6:0] code [8];
    logic [7:0] is_s;
    logic [7:0] is_t;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lane[k] = blk_d[8*k +: 8];
            is_s[k] = blk_c[k] && (lane[k] == CH_START);
            is_t[k] = blk_c[k] && (lane[k] == CH_TERM);
            // Idle maps to 0x00; Error and every other control char to 0x1E.
            code[k] = (lane[k] == CH_IDLE) ? CODE_IDLE : CODE_ERROR;
        end
    end

    // ------------------------------------------------------------------
    // Terminate search: lane n is T, every lane below is data, every lane
    // above is a control character that is neither S nor T.
    // ------------------------------------------------------------------
    logic       term_hit;
    logic [2:0] term_pos;
    logic       low_ok;
    logic       high_ok;

    always_comb begin
        term_hit = 1'b0;
        term_pos = 3'd0;
        low_ok   = 1'b1;
        high_ok  = 1'b1;
        for (int n = 0; n < 8; n++) begin
            low_ok  = 1'b1;
            high_ok = 1'b1;
            for (int j = 0; j < 8; j++) begin
                if (j < n && blk_c[j]) begin
                    low_ok = 1'b0;
                end
                if (j > n && (!blk_c[j] || is_s[j] || is_t[j])) begin
                    high_ok = 1'b0;
                end
            end
            if (!term_hit && is_t[n] && low_ok && high_ok) begin
                term_hit = 1'b1;
                term_pos = 3'(n);
            end
        end
    end

    function automatic logic [7:0] term_type(input logic [2:0] pos);
        logic [7:0] t;
        case (pos)
            3'd0:    t = 8'h87;
            3'd1:    t = 8'h99;
            3'd2:    t = 8'hAA;
            3'd3:    t = 8'hB4;
            3'd4:    t = 8'hCC;
            3'd5:    t = 8'hD2;
            3'd6:    t = 8'hE1;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Block classification, first match wins
    // ------------------------------------------------------------------
    logic [63:0] enc_txd;
    logic [1:0]  enc_hdr;

    always_comb begin
        enc_txd = ERR_BLOCK;
        enc_hdr = HDR_CTRL;
        if (blk_c == 8'h00) begin
            enc_txd = blk_d;
            enc_hdr = HDR_DATA;
        end else if (blk_c == 8'hFF && (is_s | is_t) == 8'h00) begin
            // Code for lane k sits at [7k+14 : 7k+8].
            enc_txd      = 64'd0;
            enc_txd[7:0] = TYPE_CTRL;
            for (int k = 0; k < 8; k++) begin
                enc_txd[7*k+8 +: 7] = code[k];
            end
        end else if (blk_c == 8'h01 && is_s[0]) begin
            enc_txd = {blk_d[63:8], TYPE_START0};
        end else if (blk_c == 8'h1F && is_s[4] &&
                     (is_s[3:0] | is_t[3:0]) == 4'h0) begin
            // Lane 4 (the S itself) carries no data; 4 pad bits follow C3.
            enc_txd = {blk_d[63:40], 4'h0,
                       code[3], code[2], code[1], code[0], TYPE_START4};
        end else if (term_hit) begin
            // Data lanes below T are packed from bit 8 upward; control
            // codes above T keep the same 7-bit slots as the all-control
            // block, so lane 7 ends at bit 63. Anything between is zero.
            enc_txd      = 64'd0;
            enc_txd[7:0] = term_type(term_pos);
            for (int j = 0; j < 7; j++) begin
                if (j < int'(term_pos)) begin
                    enc_txd[8*j+8 +: 8] = lane[j];
                end
            end
            for (int j = 1; j < 8; j++) begin
                if (j > int'(term_pos)) begin
                    enc_txd[7*j+8 +: 7] = code[j];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pairing state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_txc or negedge i_reset) begin
        if (!i_reset) begin
            phase       <= PH_LOW;
            lo_txd      <= 32'd0;
            lo_ctl      <= 4'd0;
            o_txd       <= IDLE_BLOCK;
            o_tx_header <= HDR_CTRL;
        end else if (!i_init_done) begin
            // Not initialised: sit in the reset state, discarding any half.
            phase       <= PH_LOW;
            lo_txd      <= 32'd0;
            lo_ctl      <= 4'd0;
            o_txd       <= IDLE_BLOCK;
            o_tx_header <= HDR_CTRL;
        end else if (!i_tx_pause) begin
            case (phase)
                PH_LOW: begin
                    lo_txd <= i_txd;
                    lo_ctl <= i_txctl;
                    phase  <= PH_HIGH;
                end
                default: begin
                    o_txd       <= enc_txd;
                    o_tx_header <= enc_hdr;
                    phase       <= PH_LOW;
                end
            endcase
        end
    end

    assign o_phase = (phase == PH_HIGH);

endmodule

// File: tb/tb_encode_6466b.sv
// ---------------------------------------------------------------------------
// tb_encode_6466b
//
// Directed bench for encode_6466b. The driver pushes the hand-computed
// encoded block into exp_q before issuing the two words; an independent
// monitor tracks the word pairing from the inputs it sees on each edge,
// pops the expected block when a pair completes and compares every cycle
// (outputs must be held between blocks and be idle under reset).
// ---------------------------------------------------------------------------
module tb_encode_6466b;

    logic        i_txc;
    logic        i_reset;
    logic        i_init_done;
    logic [31:0] i_txd;
    logic [3:0]  i_txctl;
    logic        i_tx_pause;
    logic [63:0] o_txd;
    logic [1:0]  o_tx_header;
    logic        o_phase;

    encode_6466b dut (
        .i_txc       (i_txc),
        .i_reset     (i_reset),
        .i_init_done (i_init_done),
        .i_txd       (i_txd),
        .i_txctl     (i_txctl),
        .i_tx_pause  (i_tx_pause),
        .o_txd       (o_txd),
        .o_tx_header (o_tx_header),
        .o_phase     (o_phase)
    );

    // ---------------- clock ----------------
    initial begin
        i_txc = 1'b0;
        forever #5 i_txc = ~i_txc;
    end

    // ---------------- scoreboard state ----------------
    logic [65:0] exp_q[$];     // {header, payload}
    int          checks = 0;
    int          passed = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %h, expected %h",
                      name, $time, act, exp);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [31:0] d, input logic [3:0] c,
                         input logic p);
        i_txd      = d;
        i_txctl    = c;
        i_tx_pause = p;
        @(posedge i_txc);
        #1;
    endtask

    task automatic send_block(input logic [31:0] w0, input logic [3:0] c0,
                              input logic [31:0] w1, input logic [3:0] c1,
                              input int pauses,
                              input logic [63:0] exp_txd,
                              input logic [1:0] exp_hdr);
        exp_q.push_back({exp_hdr, exp_txd});
        drive(w0, c0, 1'b0);
        for (int i = 0; i < pauses; i++) begin
            drive($urandom, 4'($urandom_range(0, 15)), 1'b1);
        end
        drive(w1, c1, 1'b0);
        i_tx_pause = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic        mdl_phase = 1'b0;
    logic [63:0] cur_txd   = 64'h1E;
    logic [1:0]  cur_hdr   = 2'b01;

    initial begin : monitor
        logic fire;
        logic init_s;
        logic rst_s;
        logic [65:0] e;
        forever begin
            @(posedge i_txc);
            rst_s  = i_reset;
            init_s = i_init_done;
            fire   = i_reset && i_init_done && !i_tx_pause;
            @(negedge i_txc);
            if (!i_reset || !rst_s || !init_s) begin
                mdl_phase = 1'b0;
                cur_txd   = 64'h1E;
                cur_hdr   = 2'b01;
            end else if (fire) begin
                if (mdl_phase) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL underflow at %0t: block seen, none expected (txd %h)",
                                 $time, o_txd);
                    end else begin
                        e       = exp_q.pop_front();
                        cur_txd = e[63:0];
                        cur_hdr = e[65:64];
                    end
                end
                mdl_phase = ~mdl_phase;
            end
            check("txd", o_txd, cur_txd);
            check("header", 64'(o_tx_header), 64'(cur_hdr));
            check("phase", 64'(o_phase), 64'(mdl_phase));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        i_reset     = 1'b0;
        i_init_done = 1'b0;
        i_tx_pause  = 1'b0;
        i_txd       = 32'h04030201;
        i_txctl     = 4'h0;
        repeat (3) @(posedge i_txc);
        #1;
        i_reset = 1'b1;
        // Released but not initialised: words must be ignored.
        for (int i = 0; i < 4; i++) drive($urandom, 4'($urandom_range(0, 15)), 1'b0);
        i_init_done = 1'b1;

        // idle pair
        send_block(32'h07070707, 4'hF, 32'h07070707, 4'hF, 0,
                   64'h000000000000001E, 2'b01);
        // start in lane 0
        send_block(32'h555555FB, 4'h1, 32'hD5555555, 4'h0, 0,
                   64'hD555555555555578, 2'b01);
        // data block
        send_block(32'h04030201, 4'h0, 32'h08070605, 4'h0, 0,
                   64'h0807060504030201, 2'b10);
        // terminate in lane 0
        send_block(32'h070707FD, 4'hF, 32'h07070707, 4'hF, 0,
                   64'h0000000000000087, 2'b01);
        // terminate in lane 4
        send_block(32'h44332211, 4'h0, 32'h070707FD, 4'hF, 0,
                   64'h00000044332211CC, 2'b01);
        // data block with 3 pause cycles between the words
        send_block(32'h04030201, 4'h0, 32'h08070605, 4'h0, 3,
                   64'h0807060504030201, 2'b10);
        // start among idles in lanes 0-3: invalid -> error block
        send_block(32'h07FB0707, 4'hF, 32'h07070707, 4'hF, 0,
                   64'h3C78F1E3C78F1E1E, 2'b01);
        // start in lane 4
        send_block(32'h07070707, 4'hF, 32'hDDCCBBFB, 4'h1, 0,
                   64'hDDCCBB0000000033, 2'b01);
        // terminate in lane 7
        send_block(32'h44332211, 4'h0, 32'hFD776655, 4'h8, 0,
                   64'h77665544332211FF, 2'b01);
        // all control, error char in lane 3
        send_block(32'hFE070707, 4'hF, 32'h07070707, 4'hF, 0,
                   64'h00000003C000001E, 2'b01);
        // terminate in lane 2, error char in lane 4
        send_block(32'h07FD2211, 4'hC, 32'h070707FE, 4'hF, 0,
                   64'h000001E0002211AA, 2'b01);
        // data after terminate: invalid -> error block
        send_block(32'h070707FD, 4'hF, 32'h07070755, 4'hE, 0,
                   64'h3C78F1E3C78F1E1E, 2'b01);

        // reset with half a block held: half must be discarded
        drive(32'hAAAAAAAA, 4'h0, 1'b0);
        #2 i_reset = 1'b0;
        @(posedge i_txc);
        #1 i_reset = 1'b1;
        send_block(32'h04030201, 4'h0, 32'h08070605, 4'h0, 0,
                   64'h0807060504030201, 2'b10);
        send_block(32'h07070707, 4'hF, 32'h07070707, 4'hF, 1,
                   64'h000000000000001E, 2'b01);

        i_tx_pause = 1'b1;
        repeat (3) @(posedge i_txc);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d blocks left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
